// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared types for the register-file writeback arbiter
package writeback_arbiter_pkg;

    // Architectural integer registers; X0 is hard-wired zero and never written.
    typedef enum logic [4:0] {
        X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
        X8,  X9,  X10, X11, X12, X13, X14, X15,
        X16, X17, X18, X19, X20, X21, X22, X23,
        X24, X25, X26, X27, X28, X29, X30, X31
    } register_e;

    // One register-file write port request.
    typedef struct packed {
        logic      write_enable;
        register_e rd_address;
        logic [31:0] write_data;
    } register_file_write_t;

    // Arbiter FSM: NORMAL lets the pipeline win, DRAIN forces one queued write.
    typedef enum logic [0:0] {
        WB_ARB_NORMAL,
        WB_ARB_DRAIN
    } wb_arb_state_e;

    // A long-latency result waiting for the write port.
    typedef struct packed {
        register_e   rd_address;
        logic [31:0] write_data;
    } wb_pending_t;

    localparam register_file_write_t WB_IDLE_WRITE = '{
        write_enable: 1'b0,
        rd_address:   X0,
        write_data:   32'h0
    };

    // A write only occupies the port when it is enabled and targets a real register.
    function automatic logic is_active_write(input register_file_write_t w);
        return w.write_enable && (w.rd_address != X0);
    endfunction

    function automatic register_file_write_t pending_to_write(input wb_pending_t p);
        register_file_write_t w;
        w.write_enable = 1'b1;
        w.rd_address   = p.rd_address;
        w.write_data   = p.write_data;
        return w;
    endfunction

endpackage

// File: rtl/writeback_pending_fifo.sv
// rtl/writeback_pending_fifo.sv - circular pending queue for long-latency results
module writeback_pending_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  wb_pending_t      push_data_i,
    input  logic             pop_i,
    output wb_pending_t      head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_pending_t      mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard push/pop so the occupancy can never over- or underflow.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        rd_ptr_d = do_pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: the count hides stale contents.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - shares the register-file write port between pipeline and MDU
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int QUEUE_DEPTH  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  register_file_write_t pipe_write_i,
    output logic                 pipe_stall_o,
    input  logic                 mdu_valid_i,
    output logic                 mdu_ready_o,
    input  register_e            mdu_rd_address_i,
    input  logic [31:0]          mdu_data_i,
    output register_file_write_t write_o
);

    localparam int CNT_W    = $clog2(QUEUE_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_arb_state_e        state_q, state_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic                 stall_q;

    logic                 pipe_active;
    logic                 head_denied;
    logic                 fifo_push;
    logic                 fifo_pop;
    wb_pending_t          fifo_push_data;
    wb_pending_t          fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Ready comes from registered occupancy only, so a same-cycle pop never raises it.
    assign mdu_ready_o = (fifo_count < CNT_W'(QUEUE_DEPTH));

    // Results for X0 are acknowledged but never stored.
    assign fifo_push                 = mdu_valid_i && !fifo_full && (mdu_rd_address_i != X0);
    assign fifo_push_data.rd_address = mdu_rd_address_i;
    assign fifo_push_data.write_data = mdu_data_i;

    assign pipe_stall_o = stall_q;

    writeback_pending_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_pending_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Port select: DRAIN forces the queue head, otherwise the pipeline has priority.
    always_comb begin
        pipe_active = is_active_write(pipe_write_i);
        fifo_pop    = 1'b0;
        head_denied = 1'b0;
        write_o     = WB_IDLE_WRITE;
        if (state_q == WB_ARB_DRAIN) begin
            if (!fifo_empty) begin
                write_o  = pending_to_write(fifo_head);
                fifo_pop = 1'b1;
            end
        end else if (pipe_active) begin
            write_o     = pipe_write_i;
            head_denied = !fifo_empty;
        end else if (!fifo_empty) begin
            write_o  = pending_to_write(fifo_head);
            fifo_pop = 1'b1;
        end
        if (rst_i) begin
            write_o.write_enable = 1'b0;
        end
    end

    // Starvation tracking: count denied cycles of the current head, drain at the limit.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (state_q == WB_ARB_DRAIN) begin
            starve_d = '0;
            state_d  = WB_ARB_NORMAL;
        end else if (head_denied) begin
            starve_d = starve_q + STARVE_W'(1);
            if (starve_d == STARVE_W'(STARVE_LIMIT)) begin
                state_d = WB_ARB_DRAIN;
            end
        end else begin
            starve_d = '0;
        end
    end

    // FSM registers with the stall output registered alongside the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= WB_ARB_NORMAL;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            stall_q  <= (state_d == WB_ARB_DRAIN);
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int QD = 2;
    localparam int SL = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    register_file_write_t pipe_write;
    logic                 pipe_stall;
    logic                 mdu_valid;
    logic                 mdu_ready;
    register_e            mdu_rd;
    logic [31:0]          mdu_data;
    register_file_write_t wr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .QUEUE_DEPTH  (QD),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .pipe_write_i     (pipe_write),
        .pipe_stall_o     (pipe_stall),
        .mdu_valid_i      (mdu_valid),
        .mdu_ready_o      (mdu_ready),
        .mdu_rd_address_i (mdu_rd),
        .mdu_data_i       (mdu_data),
        .write_o          (wr)
    );

    // Reference model: a plain queue of pending results, how long the head has
    // been refused, and whether the next cycle is a forced drain.
    wb_pending_t mq[$];
    int          head_wait;
    bit          drain_now;

    register_file_write_t obs_wr;
    logic                 obs_stall;
    logic                 obs_ready;

    typedef struct {
        register_file_write_t pw;
        logic                 v;
        register_e            rd;
        logic [31:0]          d;
        register_file_write_t ew;
        logic                 es;
        logic                 er;
    } vec_t;

    function automatic register_file_write_t mk(input bit we, input register_e rd, input logic [31:0] d);
        register_file_write_t w;
        w.write_enable = we;
        w.rd_address   = rd;
        w.write_data   = d;
        return w;
    endfunction

    task automatic chk_wr(input string name, input register_file_write_t act, input register_file_write_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got we=%0b rd=%0d data=%h, expected we=%0b rd=%0d data=%h",
                     name, act.write_enable, act.rd_address, act.write_data,
                     exp.write_enable, exp.rd_address, exp.write_data);
        end
    endtask

    task automatic chk_val(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        head_wait = 0;
        drain_now = 0;
    endtask

    // Apply one cycle of stimulus, check against the model at the falling edge,
    // then advance the model to the next cycle.
    task automatic cycle(input register_file_write_t pw, input logic v, input register_e rd, input logic [31:0] d);
        register_file_write_t ew;
        logic es, er;
        bit act;
        pipe_write = pw;
        mdu_valid  = v;
        mdu_rd     = rd;
        mdu_data   = d;
        @(negedge clk);
        act = pw.write_enable && (pw.rd_address != X0);
        er  = (mq.size() < QD);
        es  = drain_now;
        if (drain_now) begin
            ew = (mq.size() > 0) ? mk(1'b1, mq[0].rd_address, mq[0].write_data) : mk(1'b0, X0, 32'h0);
        end else if (act) begin
            ew = pw;
        end else if (mq.size() > 0) begin
            ew = mk(1'b1, mq[0].rd_address, mq[0].write_data);
        end else begin
            ew = mk(1'b0, X0, 32'h0);
        end
        obs_wr    = wr;
        obs_stall = pipe_stall;
        obs_ready = mdu_ready;
        chk_wr("model write_o", wr, ew);
        chk_val("model pipe_stall_o", int'(pipe_stall), int'(es));
        chk_val("model mdu_ready_o", int'(mdu_ready), int'(er));
        if (drain_now) begin
            if (mq.size() > 0) void'(mq.pop_front());
            drain_now = 0;
            head_wait = 0;
        end else if (act) begin
            if (mq.size() > 0) begin
                head_wait++;
                if (head_wait == SL) drain_now = 1;
            end
        end else if (mq.size() > 0) begin
            void'(mq.pop_front());
            head_wait = 0;
        end
        if (v && er && (rd != X0)) mq.push_back('{rd_address: rd, write_data: d});
        if (mq.size() == 0) head_wait = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t                 tbl[13];
        register_file_write_t busy;
        register_file_write_t idle;
        register_file_write_t pw;
        register_e            order[$];
        register_e            rd;
        int                   accepted_at;
        bit                   c_done;
        bit                   v;

        idle = mk(1'b0, X0, 32'h0);
        busy = mk(1'b1, X3, 32'h11);
        pipe_write = busy;
        mdu_valid  = 1'b1;
        mdu_rd     = X1;
        mdu_data   = 32'h0;
        model_reset();

        // Reset state, with an active pipeline request present to check the forcing.
        repeat (2) @(posedge clk);
        #1;
        chk_val("reset write_enable", int'(wr.write_enable), 0);
        chk_val("reset mdu_ready_o", int'(mdu_ready), 1);
        chk_val("reset pipe_stall_o", int'(pipe_stall), 0);
        rst = 1'b0;

        // Directed table: idle drain, starvation drain, X0 handling.
        tbl[0]  = '{idle, 1'b1, X5, 32'hDEADBEEF, mk(0, X0, 0), 1'b0, 1'b1};
        tbl[1]  = '{idle, 1'b0, X0, 32'h0, mk(1, X5, 32'hDEADBEEF), 1'b0, 1'b1};
        tbl[2]  = '{idle, 1'b0, X0, 32'h0, mk(0, X0, 0), 1'b0, 1'b1};
        tbl[3]  = '{busy, 1'b1, X7, 32'h22, busy, 1'b0, 1'b1};
        tbl[4]  = '{busy, 1'b0, X0, 32'h0, busy, 1'b0, 1'b1};
        tbl[5]  = '{busy, 1'b0, X0, 32'h0, busy, 1'b0, 1'b1};
        tbl[6]  = '{busy, 1'b0, X0, 32'h0, busy, 1'b0, 1'b1};
        tbl[7]  = '{busy, 1'b0, X0, 32'h0, busy, 1'b0, 1'b1};
        tbl[8]  = '{busy, 1'b0, X0, 32'h0, mk(1, X7, 32'h22), 1'b1, 1'b1};
        tbl[9]  = '{busy, 1'b0, X0, 32'h0, busy, 1'b0, 1'b1};
        tbl[10] = '{mk(1, X0, 32'h55), 1'b1, X9, 32'h99, mk(0, X0, 0), 1'b0, 1'b1};
        tbl[11] = '{mk(1, X0, 32'h55), 1'b1, X0, 32'h77, mk(1, X9, 32'h99), 1'b0, 1'b1};
        tbl[12] = '{idle, 1'b0, X0, 32'h0, mk(0, X0, 0), 1'b0, 1'b1};
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].pw, tbl[i].v, tbl[i].rd, tbl[i].d);
            chk_wr($sformatf("table[%0d] write_o", i), obs_wr, tbl[i].ew);
            chk_val($sformatf("table[%0d] pipe_stall_o", i), int'(obs_stall), int'(tbl[i].es));
            chk_val($sformatf("table[%0d] mdu_ready_o", i), int'(obs_ready), int'(tbl[i].er));
        end

        // Full queue with a held third offer under a busy pipeline.
        c_done      = 0;
        accepted_at = -1;
        for (int c = 0; c < 20; c++) begin
            v  = (c < 2) || !c_done;
            rd = (c == 0) ? X10 : (c == 1) ? X11 : X12;
            cycle(busy, v, rd, 32'h1000 + c);
            if (c == 2) chk_val("full mdu_ready_o", int'(obs_ready), 0);
            if (c >= 2 && v && obs_ready && !c_done) begin
                c_done      = 1;
                accepted_at = c;
            end
            if (obs_stall) order.push_back(obs_wr.rd_address);
        end
        chk_val("held offer accept cycle", accepted_at, 6);
        chk_val("drain count", order.size(), 3);
        if (order.size() == 3) begin
            chk_val("drain order 0", int'(order[0]), int'(X10));
            chk_val("drain order 1", int'(order[1]), int'(X11));
            chk_val("drain order 2", int'(order[2]), int'(X12));
        end

        // Push and pop together at count 1, across pointer wrap.
        cycle(idle, 1'b1, X20, 32'h600);
        for (int k = 1; k <= 5; k++) begin
            cycle(idle, 1'b1, register_e'(20 + k), 32'h600 + k);
            chk_wr($sformatf("pushpop[%0d] write_o", k), obs_wr, mk(1, register_e'(19 + k), 32'h600 + k - 1));
            chk_val($sformatf("pushpop[%0d] ready", k), int'(obs_ready), 1);
        end
        cycle(idle, 1'b0, X0, 32'h0);
        chk_wr("pushpop tail write_o", obs_wr, mk(1, X25, 32'h605));

        // Reset mid-stream with two entries queued.
        cycle(busy, 1'b1, X13, 32'hAAAA);
        cycle(busy, 1'b1, X14, 32'hBBBB);
        pipe_write = busy;
        mdu_valid  = 1'b0;
        rst = 1'b1;
        #1;
        chk_val("midreset write_enable", int'(wr.write_enable), 0);
        chk_val("midreset mdu_ready_o", int'(mdu_ready), 1);
        chk_val("midreset pipe_stall_o", int'(pipe_stall), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 8; c++) begin
            cycle(idle, 1'b0, X0, 32'h0);
            chk_val("post-reset no write", int'(obs_wr.write_enable), 0);
        end

        // Randomised traffic against the model; a stalled write is held.
        pw = idle;
        for (int c = 0; c < 400; c++) begin
            if (c == 0 || !obs_stall) begin
                pw = mk($urandom_range(0, 99) < 70, register_e'($urandom_range(0, 31)), $urandom);
            end
            v  = ($urandom_range(0, 99) < 40);
            rd = ($urandom_range(0, 7) == 0) ? X0 : register_e'($urandom_range(1, 31));
            cycle(pw, v, rd, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
